// File: rtl/nanorv32_tcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_tcm_pkg
//  Description : Shared constants and helpers for the TCM crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
package nanorv32_tcm_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int BYTESEL_W = 4;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2, never below 1 so single-entry selects keep a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nanorv32_tcm_xbar_if.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_tcm_xbar_if
//  Description : Master-side and bank-side signal bundle of the TCM crossbar.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nanorv32_tcm_xbar_if #(
    parameter int NM = 2,
    parameter int NB = 2,
    parameter int AW = 13
);
    import nanorv32_tcm_pkg::*;

    logic [NM-1:0]           m_req;
    logic [NM*ADDR_W-1:0]    m_addr;
    logic [NM*DATA_W-1:0]    m_wdata;
    logic [NM*BYTESEL_W-1:0] m_bytesel;
    logic [NM-1:0]           m_early_ready;
    logic [NM-1:0]           m_ready_r;
    logic [NM*DATA_W-1:0]    m_rdata;
    logic [NM-1:0]           m_err_r;
    logic [NB-1:0]           b_en;
    logic [NB*AW-1:0]        b_addr;
    logic [NB*BYTESEL_W-1:0] b_bytesel;
    logic [NB*DATA_W-1:0]    b_din;
    logic [NB*DATA_W-1:0]    b_dout;
    logic [NB-1:0]           b_ready_nxt;

    // Crossbar side
    modport slave (
        input  m_req, m_addr, m_wdata, m_bytesel, b_dout, b_ready_nxt,
        output m_early_ready, m_ready_r, m_rdata, m_err_r,
               b_en, b_addr, b_bytesel, b_din
    );

    // Environment side: requesting masters plus the banks
    modport master (
        output m_req, m_addr, m_wdata, m_bytesel, b_dout, b_ready_nxt,
        input  m_early_ready, m_ready_r, m_rdata, m_err_r,
               b_en, b_addr, b_bytesel, b_din
    );

endinterface
`default_nettype wire

// File: rtl/nanorv32_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_rr_arbiter
//  Description : One-hot N-way arbiter, fixed priority or round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module nanorv32_rr_arbiter
    import nanorv32_tcm_pkg::*;
#(
    parameter int N = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [N-1:0] req,
    input  wire logic         en,
    input  wire logic         mode,
    output logic      [N-1:0] gnt
);
    localparam int c_pw = clog2(N);

    logic [c_pw-1:0] r_ptr;
    logic [c_pw-1:0] w_win;
    logic            w_found;
    int              w_base;
    int              w_dist;
    int              w_best;

    // Winner is the requester with the smallest rotated distance from the base.
    always_comb begin
        w_win   = '0;
        w_base  = mode ? int'(r_ptr) : 0;
        w_dist  = 0;
        w_best  = N;
        for (int m = 0; m < N; m++) begin
            w_dist = m - w_base;
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (req[m] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = c_pw'(m);
            end
        end
        w_found = (w_best < N);
    end

    always_comb begin
        gnt = '0;
        for (int m = 0; m < N; m++) begin
            gnt[m] = en & w_found & (w_win == c_pw'(m));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nanorv32_tcm_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_tcm_xbar
//  Description : N-master x M-bank TCM crossbar with per-bank arbitration and
//                a registered one-cycle response path.
//  Revision    : 1.0 - initial release
// ============================================================================
module nanorv32_tcm_xbar
    import nanorv32_tcm_pkg::*;
#(
    parameter int NM       = 2,
    parameter int NB       = 2,
    parameter int BANK_LSB = 15,
    parameter int ARB_MODE = ARB_RR
) (
    input  wire logic          clk,
    input  wire logic          rst,
    nanorv32_tcm_xbar_if.slave bus
);
    localparam int   BW        = clog2(NB);
    localparam int   AW        = BANK_LSB - 2;
    localparam int   c_mw      = clog2(NM);
    localparam logic c_rr_mode = (ARB_MODE == ARB_RR);

    logic [NM-1:0]   w_dec_err;
    logic [BW-1:0]   w_bank   [NM];
    logic [NM-1:0]   w_breq   [NB];
    logic [NM-1:0]   w_gnt    [NB];
    logic [c_mw-1:0] w_win    [NB];
    logic [NB-1:0]   w_win_rd;
    logic [NM-1:0]   w_early;

    logic [NB-1:0]   r_vld;
    logic [NB-1:0]   r_rd;
    logic [c_mw-1:0] r_own    [NB];
    logic [NM-1:0]   r_err;

    for (genvar m = 0; m < NM; m++) begin : g_dec
        logic [ADDR_W-1:0] w_a;
        logic              w_oob;
        assign w_a       = bus.m_addr[m*ADDR_W +: ADDR_W];
        assign w_bank[m] = w_a[BANK_LSB +: BW];
        // Only a non-power-of-two span of the bank field can miss a bank.
        if (NB < (1 << BW)) begin : g_partial
            assign w_oob = (int'(w_bank[m]) >= NB);
        end else begin : g_full
            assign w_oob = 1'b0;
        end
        assign w_dec_err[m] = bus.m_req[m] & (((w_a >> (BANK_LSB + BW)) != '0) | w_oob);
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_breq[b] = '0;
            for (int m = 0; m < NM; m++) begin
                w_breq[b][m] = bus.m_req[m] & ~w_dec_err[m] & (w_bank[m] == BW'(b));
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        nanorv32_rr_arbiter #(
            .N (NM)
        ) u_arb (
            .clk  (clk),
            .rst  (rst),
            .req  (w_breq[b]),
            .en   (bus.b_ready_nxt[b]),
            .mode (c_rr_mode),
            .gnt  (w_gnt[b])
        );
    end

    // Route each bank's winner onto the bank port; decode errors accept at once.
    always_comb begin
        bus.b_en      = '0;
        bus.b_addr    = '0;
        bus.b_bytesel = '0;
        bus.b_din     = '0;
        w_early       = w_dec_err;
        w_win_rd      = '0;
        for (int b = 0; b < NB; b++) begin
            w_win[b]     = '0;
            bus.b_en[b]  = |w_gnt[b];
            for (int m = 0; m < NM; m++) begin
                if (w_gnt[b][m]) begin
                    w_win[b]    = c_mw'(m);
                    w_win_rd[b] = (bus.m_bytesel[m*BYTESEL_W +: BYTESEL_W] == '0);
                    bus.b_addr[b*AW +: AW] = bus.m_addr[m*ADDR_W + 2 +: AW];
                    bus.b_bytesel[b*BYTESEL_W +: BYTESEL_W] =
                        bus.m_bytesel[m*BYTESEL_W +: BYTESEL_W];
                    bus.b_din[b*DATA_W +: DATA_W] = bus.m_wdata[m*DATA_W +: DATA_W];
                    w_early[m]  = 1'b1;
                end
            end
        end
    end

    assign bus.m_early_ready = w_early;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_rd  <= '0;
            r_err <= '0;
            for (int b = 0; b < NB; b++) begin
                r_own[b] <= '0;
            end
        end else begin
            r_vld <= bus.b_en;
            r_rd  <= w_win_rd;
            r_err <= w_dec_err;
            for (int b = 0; b < NB; b++) begin
                r_own[b] <= w_win[b];
            end
        end
    end

    // Bank read data lands the cycle after the grant, so it is steered live.
    always_comb begin
        bus.m_ready_r = r_err;
        bus.m_err_r   = r_err;
        bus.m_rdata   = '0;
        for (int b = 0; b < NB; b++) begin
            for (int m = 0; m < NM; m++) begin
                if (r_vld[b] && (r_own[b] == c_mw'(m))) begin
                    bus.m_ready_r[m] = 1'b1;
                    if (r_rd[b]) begin
                        bus.m_rdata[m*DATA_W +: DATA_W] = bus.b_dout[b*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
